spectrum_capture_ctrl: RTL and testbench
========================================

Name: spectrum_capture_ctrl

Overview:
- Parametrised successor to the FFT start/RAM write-control pair in the modulation-analysis chain. It sequences the FFT core (reset pulse, frame capture), writes the lower half-spectrum magnitudes into the spectrum RAM and tracks the spectral peak.
- Adds an auto-retrigger timer, downstream read-lock, a one-deep trigger queue and a stall timeout.
- Sits between data_modulus, the spectrum RAM and modulation_detect, all in the 50 MHz domain.

Parameters:
- DATA_W, 16: magnitude / RAM word width.
- ADDR_W, 8: RAM address width; stored bins = 2^ADDR_W; FFT length N = 2^(ADDR_W+1).
- AUTO_PERIOD, 25_000_000: auto-trigger interval in clk cycles (0.5 s at 50 MHz).
- RST_CYC, 8: cycles fft_aresetn is held low per capture.
- SKIP_BINS, 2: low bins (DC) excluded from peak search.
- TIMEOUT, 65535: maximum idle cycles between mag_valid beats before abort.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  synchronous, active-high reset.
- start  in  1  manual trigger, single-cycle pulse (debounced key).
- auto_en  in  1  enables the periodic auto-trigger.
- rd_busy  in  1  downstream is reading the RAM; captures are deferred while high.
- mag_data  in  DATA_W  FFT magnitude sample.
- mag_valid  in  1  mag_data qualifier, one beat per bin, bins in natural order.
- fft_aresetn  out  1  FFT core reset, active low.
- wr_en  out  1  RAM write enable.
- wr_addr  out  ADDR_W  RAM write address.
- wr_data  out  DATA_W  RAM write data.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse when a frame is complete.
- timeout_err  out  1  sticky; cleared by the next successful frame_done.
- peak_bin  out  ADDR_W  index of the maximum bin, latched at frame_done.
- peak_mag  out  DATA_W  magnitude of the maximum bin, latched at frame_done.

Behaviour:
- Fixed: one clock domain, clk; reset rst is synchronous and active-high.
- Reset values: fft_aresetn=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, timeout_err=0, peak_bin=0, peak_mag=0. State=IDLE, pending flag cleared, auto timer=0.
- Auto timer:
  - Counts while auto_en=1 and wraps at AUTO_PERIOD-1; the wrap cycle is an auto trigger.
  - auto_en=0 clears the timer.
- Trigger = start OR auto trigger.
- Trigger in IDLE with rd_busy=0: go to FFT_RST next cycle.
- Trigger while busy or while rd_busy=1: set pending. Pending is one-deep; extra triggers are dropped.
- Pending is launched from IDLE on the first cycle with rd_busy=0.
- States:
  - IDLE: fft_aresetn=1.
  - FFT_RST: fft_aresetn=0 for exactly RST_CYC cycles. Clear the bin counter and peak trackers. Go to CAPTURE. mag_valid is ignored in this state.
  - CAPTURE:
    - On each mag_valid, register wr_en=1, wr_addr=bin count, wr_data=mag_data; the write appears one cycle after the beat.
    - After bin 2^ADDR_W-1, go to DRAIN.
  - DRAIN: count and discard the remaining 2^ADDR_W beats (upper mirror half), then go to DONE.
  - DONE:
    - frame_done=1 for one cycle; peak_bin/peak_mag update in the same cycle; timeout_err cleared.
    - Go to IDLE.
    - With the default parameters (ADDR_W=8, N=512), frame_done follows the 512th mag_valid beat by exactly 1 cycle.
- Peak search:
  - Covers bins with index ≥ SKIP_BINS.
  - Update only on strictly greater magnitude, so the first maximum wins on ties.
  - If SKIP_BINS ≥ 2^ADDR_W, report peak 0/0.
- Timeout:
  - In CAPTURE/DRAIN, an idle counter resets on every mag_valid.
  - Reaching TIMEOUT sets timeout_err and returns to IDLE with no frame_done; peak outputs keep their old values.
  - RAM contents are then partial; downstream must not consume them.
- wr_en is never asserted outside CAPTURE. The write address never wraps; beats beyond bin 2^ADDR_W-1 go to DRAIN.
- rst mid-frame: immediate return to reset values, pending lost, no frame_done.
- start coinciding with an auto trigger counts as one trigger.

Optional Feature:
- Macro: SPECTRUM_CAPTURE_PEAK_EN.
- Defined: peak tracking as specified above.
- Undefined: peak logic is removed; peak_bin and peak_mag are tied to 0. All other behaviour is unchanged.

Test Plan:
- Bench parameters: ADDR_W=3 (8 bins, N=16), RST_CYC=4, AUTO_PERIOD=100, TIMEOUT=20, SKIP_BINS=2.
- Scenario 1: start pulse, then 16 back-to-back beats with mag_data = 10,90,3,7,50,50,1,2, then 8 further beats → fft_aresetn low exactly 4 cycles; 8 writes at addr 0..7 carrying those values; frame_done 1 cycle after beat 16; peak_bin=4, peak_mag=50 (DC 90 skipped, tie gives first).
- Scenario 2: auto_en=1, no start, beats fed on each fft_aresetn release → frame_done pulses spaced by the 100-cycle trigger period; no wr_en outside CAPTURE.
- Scenario 3: start twice during CAPTURE, then a third start → exactly one extra capture after DONE; the third trigger is dropped.
- Scenario 4: rd_busy=1 across a trigger, released 30 cycles later → fft_aresetn falls on the cycle after rd_busy drops, not before.
- Scenario 5: stop mag_valid after 5 beats → timeout_err=1 after 20 idle cycles, state IDLE, no frame_done, peak outputs unchanged; the next good frame clears timeout_err.
- Scenario 6: rst during DRAIN → all outputs at reset values the next cycle; no frame_done; a following start runs normally.

Source files
------------

// File: rtl/spectrum_capture_ctrl.sv
// Capture sequencer for the FFT core: reset pulse, lower half-spectrum RAM writes, peak tracking.
// Optional peak tracking is built only when SPECTRUM_CAPTURE_PEAK_EN is defined.
module spectrum_capture_ctrl #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int AUTO_PERIOD = 25_000_000,
  parameter int RST_CYC     = 8,
  parameter int SKIP_BINS   = 2,
  parameter int TIMEOUT     = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              auto_en,
  input  logic              rd_busy,
  input  logic [DATA_W-1:0] mag_data,
  input  logic              mag_valid,
  output logic              fft_aresetn,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              timeout_err,
  output logic [ADDR_W-1:0] peak_bin,
  output logic [DATA_W-1:0] peak_mag
);

  localparam int CW = ADDR_W + 1;
  localparam int AW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD + 1) : 1;
  localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC + 1) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    FFT_RST,
    CAPTURE,
    DRAIN,
    DONE
  } state_t;

  state_t state_reg, state_next;

  logic [AW-1:0]     auto_cnt_reg;
  logic [RW-1:0]     rst_cnt_reg;
  logic [CW-1:0]     bin_cnt_reg;
  logic [TW-1:0]     idle_cnt_reg;
  logic              pending_reg;
  logic              fft_aresetn_reg;
  logic              wr_en_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [DATA_W-1:0] wr_data_reg;
  logic              timeout_err_reg;

  logic auto_trig;
  logic trigger;
  logic launch;
  logic abort;
  logic idle_expired;
  logic in_frame;

  assign auto_trig    = auto_en && (auto_cnt_reg == AW'(AUTO_PERIOD - 1));
  assign trigger      = start || auto_trig;
  assign in_frame     = (state_reg == CAPTURE) || (state_reg == DRAIN);
  assign idle_expired = !mag_valid && (idle_cnt_reg == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    launch     = 1'b0;
    abort      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rd_busy && (trigger || pending_reg)) begin
          state_next = FFT_RST;
          launch     = 1'b1;
        end
      end
      FFT_RST: begin
        if (rst_cnt_reg == RW'(RST_CYC - 1)) begin
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        if (idle_expired) begin
          state_next = IDLE;
          abort      = 1'b1;
        end else if (mag_valid && (bin_cnt_reg == CW'((2 ** ADDR_W) - 1))) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (idle_expired) begin
          state_next = IDLE;
          abort      = 1'b1;
        end else if (mag_valid && (bin_cnt_reg == {CW{1'b1}})) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Auto timer and the one-deep trigger queue; a trigger that launches directly never queues.
  always_ff @(posedge clk) begin
    if (rst) begin
      auto_cnt_reg <= '0;
      pending_reg  <= 1'b0;
    end else begin
      if (!auto_en || auto_trig) begin
        auto_cnt_reg <= '0;
      end else begin
        auto_cnt_reg <= auto_cnt_reg + 1'b1;
      end
      if (launch) begin
        pending_reg <= 1'b0;
      end else if (trigger) begin
        pending_reg <= 1'b1;
      end
    end
  end

  // Frame counters: bin_cnt spans both halves, its MSB marks the discarded mirror half.
  always_ff @(posedge clk) begin
    if (rst) begin
      rst_cnt_reg  <= '0;
      bin_cnt_reg  <= '0;
      idle_cnt_reg <= '0;
    end else begin
      if (state_reg == FFT_RST) begin
        rst_cnt_reg <= rst_cnt_reg + 1'b1;
      end else begin
        rst_cnt_reg <= '0;
      end
      if (state_reg == FFT_RST) begin
        bin_cnt_reg <= '0;
      end else if (in_frame && mag_valid) begin
        bin_cnt_reg <= bin_cnt_reg + 1'b1;
      end
      if (in_frame && !mag_valid) begin
        idle_cnt_reg <= idle_cnt_reg + 1'b1;
      end else begin
        idle_cnt_reg <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fft_aresetn_reg <= 1'b0;
      wr_en_reg       <= 1'b0;
      wr_addr_reg     <= '0;
      wr_data_reg     <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      fft_aresetn_reg <= (state_next != FFT_RST);
      wr_en_reg       <= (state_reg == CAPTURE) && mag_valid;
      if ((state_reg == CAPTURE) && mag_valid) begin
        wr_addr_reg <= bin_cnt_reg[ADDR_W-1:0];
        wr_data_reg <= mag_data;
      end
      if (abort) begin
        timeout_err_reg <= 1'b1;
      end else if (state_next == DONE) begin
        timeout_err_reg <= 1'b0;
      end
    end
  end

`ifdef SPECTRUM_CAPTURE_PEAK_EN
  logic [ADDR_W-1:0] best_bin_reg;
  logic [DATA_W-1:0] best_mag_reg;
  logic [ADDR_W-1:0] peak_bin_reg;
  logic [DATA_W-1:0] peak_mag_reg;

  // Strictly-greater update keeps the first of equal maxima.
  always_ff @(posedge clk) begin
    if (rst) begin
      best_bin_reg <= '0;
      best_mag_reg <= '0;
      peak_bin_reg <= '0;
      peak_mag_reg <= '0;
    end else begin
      if (state_reg == FFT_RST) begin
        best_bin_reg <= '0;
        best_mag_reg <= '0;
      end else if ((state_reg == CAPTURE) && mag_valid &&
                   (int'(bin_cnt_reg) >= SKIP_BINS) && (mag_data > best_mag_reg)) begin
        best_bin_reg <= bin_cnt_reg[ADDR_W-1:0];
        best_mag_reg <= mag_data;
      end
      if (state_next == DONE) begin
        peak_bin_reg <= best_bin_reg;
        peak_mag_reg <= best_mag_reg;
      end
    end
  end

  assign peak_bin = peak_bin_reg;
  assign peak_mag = peak_mag_reg;
`else
  assign peak_bin = '0;
  assign peak_mag = '0;
`endif

  assign fft_aresetn = fft_aresetn_reg;
  assign wr_en       = wr_en_reg;
  assign wr_addr     = wr_addr_reg;
  assign wr_data     = wr_data_reg;
  assign busy        = (state_reg != IDLE);
  assign frame_done  = (state_reg == DONE);
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_spectrum_capture_ctrl.sv
// Directed bench for spectrum_capture_ctrl: 8-bin configuration (N=16), hand-computed expectations.
module tb_spectrum_capture_ctrl;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

`ifdef SPECTRUM_CAPTURE_PEAK_EN
  localparam bit PEAK_ON = 1'b1;
`else
  localparam bit PEAK_ON = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              start;
  logic              auto_en;
  logic              rd_busy;
  logic [DATA_W-1:0] mag_data;
  logic              mag_valid;
  logic              fft_aresetn;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              frame_done;
  logic              timeout_err;
  logic [ADDR_W-1:0] peak_bin;
  logic [DATA_W-1:0] peak_mag;

  spectrum_capture_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .AUTO_PERIOD(100),
    .RST_CYC(4), .SKIP_BINS(2), .TIMEOUT(20)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .auto_en(auto_en), .rd_busy(rd_busy),
    .mag_data(mag_data), .mag_valid(mag_valid), .fft_aresetn(fft_aresetn),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .frame_done(frame_done), .timeout_err(timeout_err),
    .peak_bin(peak_bin), .peak_mag(peak_mag)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fd_cnt = 0;
  int wr_cnt = 0;
  int bad_wr = 0;
  logic [ADDR_W-1:0] log_addr [0:255];
  logic [DATA_W-1:0] log_data [0:255];
  logic [DATA_W-1:0] beat [0:15];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Outputs observed mid-cycle; a write is illegal during the FFT reset pulse, in IDLE or in DONE.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done) fd_cnt <= fd_cnt + 1;
      if (wr_en) begin
        log_addr[wr_cnt[7:0]] <= wr_addr;
        log_data[wr_cnt[7:0]] <= wr_data;
        wr_cnt <= wr_cnt + 1;
        if (!fft_aresetn || !busy || frame_done) bad_wr <= bad_wr + 1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_default();
    logic [DATA_W-1:0] vals [0:7];
    vals = '{16'd10, 16'd90, 16'd3, 16'd7, 16'd50, 16'd50, 16'd1, 16'd2};
    for (int i = 0; i < 8; i++) beat[i] = vals[i];
    for (int i = 8; i < 16; i++) beat[i] = 16'd200;
  endtask

  task automatic feed(input int first, input int n, input logic [15:0] starts);
    for (int i = first; i < first + n; i++) begin
      mag_valid = 1'b1;
      mag_data  = beat[i];
      start     = starts[i];
      tick();
    end
    mag_valid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic wait_rst_low(output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 300; i++) begin
      if (!fft_aresetn) begin
        ok = 1'b1;
        break;
      end
      tick();
      n++;
    end
  endtask

  task automatic wait_release(output int low_cyc, output bit ok);
    ok      = 1'b0;
    low_cyc = 0;
    for (int i = 0; i < 50; i++) begin
      if (fft_aresetn) begin
        ok = 1'b1;
        break;
      end
      low_cyc++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; auto_en = 1'b0; rd_busy = 1'b0;
    mag_valid = 1'b0; mag_data = '0;
    tick(); tick(); tick();
    checks++;
    if ({fft_aresetn, wr_en, busy, frame_done, timeout_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, expected 00000", {fft_aresetn, wr_en, busy, frame_done, timeout_err});
    end
    checks++;
    if ({wr_addr, wr_data, peak_bin, peak_mag} !== '0) begin
      errors++;
      $display("FAIL reset_buses: got addr=%0d data=%0d pbin=%0d pmag=%0d, expected all 0", wr_addr, wr_data, peak_bin, peak_mag);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (fft_aresetn !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got aresetn=%b busy=%b, expected 1 0", fft_aresetn, busy);
    end
  endtask

  task automatic test_single_frame();
    int w0, f0, low;
    bit ok;
    load_default();
    w0 = wr_cnt; f0 = fd_cnt;
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (fft_aresetn !== 1'b0) begin
      errors++;
      $display("FAIL s1_fall: got aresetn=%b, expected 0", fft_aresetn);
    end
    wait_release(low, ok);
    checks++;
    if (!ok || low != 4) begin
      errors++;
      $display("FAIL s1_rst_len: got %0d low cycles (released=%0d), expected 4", low, ok);
    end
    feed(0, 15, 16'h0);
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL s1_done_early: got frame_done=%b after beat 15, expected 0", frame_done);
    end
    feed(15, 1, 16'h0);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL s1_done: got frame_done=%b after beat 16, expected 1", frame_done);
    end
    checks++;
    if (peak_bin !== (PEAK_ON ? 3'd4 : 3'd0) || peak_mag !== (PEAK_ON ? 16'd50 : 16'd0)) begin
      errors++;
      $display("FAIL s1_peak: got %0d/%0d, expected %0d/%0d", peak_bin, peak_mag, PEAK_ON ? 4 : 0, PEAK_ON ? 50 : 0);
    end
    tick();
    checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL s1_done_pulse: got frame_done=%b busy=%b, expected 0 0", frame_done, busy);
    end
    checks++;
    if (wr_cnt - w0 != 8 || fd_cnt - f0 != 1) begin
      errors++;
      $display("FAIL s1_counts: got writes=%0d dones=%0d, expected 8 1", wr_cnt - w0, fd_cnt - f0);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (log_addr[w0 + i] !== 3'(i) || log_data[w0 + i] !== beat[i]) begin
        errors++;
        $display("FAIL s1_write%0d: got addr=%0d data=%0d, expected addr=%0d data=%0d", i, log_addr[w0 + i], log_data[w0 + i], i, beat[i]);
      end
    end
    $display("frame: peak_bin=%0d peak_mag=%0d writes=%0d", peak_bin, peak_mag, wr_cnt - w0);
  endtask

  task automatic test_auto_trigger();
    int c0, n, low, t_done [0:2];
    bit ok;
    load_default();
    c0 = cyc;
    auto_en = 1'b1;
    for (int f = 0; f < 3; f++) begin
      wait_rst_low(n, ok);
      if (f == 0) begin
        checks++;
        if (!ok || cyc - c0 != 100) begin
          errors++;
          $display("FAIL s2_first_trig: got fall %0d cycles after enable (seen=%0d), expected 100", cyc - c0, ok);
        end
      end
      wait_release(low, ok);
      feed(0, 16, 16'h0);
      t_done[f] = cyc;
      checks++;
      if (frame_done !== 1'b1) begin
        errors++;
        $display("FAIL s2_done%0d: got frame_done=%b, expected 1", f, frame_done);
      end
      $display("auto frame %0d done at cycle %0d", f, cyc);
    end
    auto_en = 1'b0;
    for (int f = 1; f < 3; f++) begin
      checks++;
      if (t_done[f] - t_done[f-1] != 100) begin
        errors++;
        $display("FAIL s2_spacing%0d: got %0d, expected 100", f, t_done[f] - t_done[f-1]);
      end
    end
    low = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (!fft_aresetn) low++;
    end
    checks++;
    if (low != 0 || bad_wr != 0) begin
      errors++;
      $display("FAIL s2_quiet: got %0d low cycles, %0d stray writes, expected 0 0", low, bad_wr);
    end
  endtask

  task automatic test_back_to_back();
    int f0, n, low;
    bit ok;
    load_default();
    f0 = fd_cnt;
    start = 1'b1; tick(); start = 1'b0;
    wait_release(low, ok);
    feed(0, 16, 16'h0424);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL s3_done1: got frame_done=%b, expected 1", frame_done);
    end
    wait_rst_low(n, ok);
    checks++;
    if (!ok || n != 2) begin
      errors++;
      $display("FAIL s3_relaunch: got fall after %0d cycles (seen=%0d), expected 2", n, ok);
    end
    wait_release(low, ok);
    feed(0, 16, 16'h0);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL s3_done2: got frame_done=%b, expected 1", frame_done);
    end
    low = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!fft_aresetn) low++;
    end
    checks++;
    if (low != 0 || fd_cnt - f0 != 2) begin
      errors++;
      $display("FAIL s3_dropped: got %0d low cycles, %0d dones, expected 0 2", low, fd_cnt - f0);
    end
    $display("back-to-back: %0d frames", fd_cnt - f0);
  endtask

  task automatic test_rd_busy();
    int low, nbusy;
    bit ok;
    load_default();
    rd_busy = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    low = 0; nbusy = 0;
    for (int i = 0; i < 30; i++) begin
      if (!fft_aresetn) low++;
      if (busy) nbusy++;
      tick();
    end
    checks++;
    if (low != 0 || nbusy != 0) begin
      errors++;
      $display("FAIL s4_deferred: got %0d low, %0d busy cycles, expected 0 0", low, nbusy);
    end
    rd_busy = 1'b0;
    tick();
    checks++;
    if (fft_aresetn !== 1'b0) begin
      errors++;
      $display("FAIL s4_launch: got aresetn=%b cycle after release, expected 0", fft_aresetn);
    end
    wait_release(low, ok);
    feed(0, 16, 16'h0);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL s4_done: got frame_done=%b, expected 1", frame_done);
    end
    tick();
  endtask

  task automatic test_timeout();
    int f0, k, low;
    bit ok;
    logic [ADDR_W-1:0] pb0;
    logic [DATA_W-1:0] pm0;
    pb0 = peak_bin; pm0 = peak_mag;
    f0 = fd_cnt;
    beat[0] = 16'd0; beat[1] = 16'd0; beat[2] = 16'd500; beat[3] = 16'd600; beat[4] = 16'd700;
    start = 1'b1; tick(); start = 1'b0;
    wait_release(low, ok);
    feed(0, 5, 16'h0);
    k = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      k++;
      if (timeout_err) break;
    end
    checks++;
    if (timeout_err !== 1'b1 || k != 20) begin
      errors++;
      $display("FAIL s5_timeout: got err=%b after %0d idle cycles, expected 1 after 20", timeout_err, k);
    end
    checks++;
    if (busy !== 1'b0 || fd_cnt != f0) begin
      errors++;
      $display("FAIL s5_abort: got busy=%b dones=%0d, expected 0 0", busy, fd_cnt - f0);
    end
    checks++;
    if (peak_bin !== pb0 || peak_mag !== pm0) begin
      errors++;
      $display("FAIL s5_peak_hold: got %0d/%0d, expected %0d/%0d", peak_bin, peak_mag, pb0, pm0);
    end
    tick(); tick(); tick();
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL s5_sticky: got err=%b, expected 1", timeout_err);
    end
    load_default();
    start = 1'b1; tick(); start = 1'b0;
    wait_release(low, ok);
    feed(0, 15, 16'h0);
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL s5_err_mid: got err=%b before frame_done, expected 1", timeout_err);
    end
    feed(15, 1, 16'h0);
    checks++;
    if (frame_done !== 1'b1 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL s5_clear: got done=%b err=%b, expected 1 0", frame_done, timeout_err);
    end
    $display("timeout frame: idle=%0d, recovery err=%b", k, timeout_err);
    tick();
  endtask

  task automatic test_reset_in_drain();
    int f0, w0, low;
    bit ok;
    load_default();
    f0 = fd_cnt;
    start = 1'b1; tick(); start = 1'b0;
    wait_release(low, ok);
    feed(0, 10, 16'h0008);
    rst = 1'b1;
    tick();
    checks++;
    if ({fft_aresetn, wr_en, busy, frame_done, timeout_err} !== 5'b0 ||
        {wr_addr, wr_data, peak_bin, peak_mag} !== '0) begin
      errors++;
      $display("FAIL s6_reset: got flags=%b addr=%0d data=%0d peak=%0d/%0d, expected all 0",
               {fft_aresetn, wr_en, busy, frame_done, timeout_err}, wr_addr, wr_data, peak_bin, peak_mag);
    end
    rst = 1'b0;
    tick();
    low = 0;
    for (int i = 0; i < 30; i++) begin
      if (!fft_aresetn) low++;
      tick();
    end
    checks++;
    if (low != 0 || fd_cnt != f0) begin
      errors++;
      $display("FAIL s6_pending_lost: got %0d low cycles, %0d dones, expected 0 0", low, fd_cnt - f0);
    end
    w0 = wr_cnt;
    start = 1'b1; tick(); start = 1'b0;
    wait_release(low, ok);
    feed(0, 16, 16'h0);
    checks++;
    if (frame_done !== 1'b1 || peak_bin !== (PEAK_ON ? 3'd4 : 3'd0) || peak_mag !== (PEAK_ON ? 16'd50 : 16'd0)) begin
      errors++;
      $display("FAIL s6_rerun: got done=%b peak=%0d/%0d", frame_done, peak_bin, peak_mag);
    end
    tick();
    checks++;
    if (wr_cnt - w0 != 8 || log_addr[w0 + 7] !== 3'd7 || log_data[w0 + 7] !== 16'd2) begin
      errors++;
      $display("FAIL s6_writes: got %0d writes, last addr=%0d data=%0d, expected 8 7 2", wr_cnt - w0, log_addr[w0 + 7], log_data[w0 + 7]);
    end
    $display("post-reset frame: writes=%0d", wr_cnt - w0);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_auto_trigger();
    test_back_to_back();
    test_rd_busy();
    test_timeout();
    test_reset_in_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
